// File: rtl/edge_pattern_gen_pkg.sv
// Shared types for the edge/pulse-train generator.
// FSM encoding and default field width.
package edge_gen_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/edge_pattern_gen_if.sv
// Control/status bundle of the edge/pulse-train generator.
// master drives config and commands, slave drives waveform and status.
interface edge_pattern_gen_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic [CNT_W-1:0] num_pulses;
    logic             wave_out;
    logic             rise_strobe;
    logic             fall_strobe;
    logic             busy;
    logic             done;

    modport master (
        output start, stop,
        output high_cycles, low_cycles, num_pulses,
        input  wave_out, rise_strobe, fall_strobe,
        input  busy, done
    );

    modport slave (
        input  start, stop,
        input  high_cycles, low_cycles, num_pulses,
        output wave_out, rise_strobe, fall_strobe,
        output busy, done
    );
endinterface

// File: rtl/edge_pattern_gen_phase_counter.sv
// Loadable down-counter timing one phase of the train.
// last_o is registered and high during the final cycle of the phase.
module phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             dec_i,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (load_i) begin
            cnt_d  = len_i;
            last_d = (len_i == CNT_W'(1));
        end else if (dec_i && cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            last_d = (cnt_q == CNT_W'(2));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign last_o = last_q;
endmodule

// File: rtl/edge_pattern_gen.sv
// Programmable square-wave / pulse-train generator with edge strobes.
// FSM, pulse counter and config latches; phase timing in phase_counter.
module edge_pattern_gen
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input logic          clk,
    input logic          reset,
    edge_pattern_gen_if.slave bus
);
    state_e           state_q;
    logic [CNT_W-1:0] h_q, l_q, n_q, pcnt_q;
    logic             wave_q, rise_q, fall_q, busy_q, done_q;

    logic             last;
    logic             accept, high_end, low_end, more;
    logic             ld_d, dec_d;
    logic [CNT_W-1:0] len_d;

    function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    always_comb begin
        accept   = (state_q == IDLE) && bus.start && !bus.stop;
        high_end = (state_q == HIGH) && last && !bus.stop;
        low_end  = (state_q == LOW) && last && !bus.stop;
        // pulse count compares against N-1 so it never has to reach N
        more     = (n_q == '0) || (pcnt_q != n_q - CNT_W'(1));
        ld_d     = accept || high_end || (low_end && more);
        dec_d    = (state_q != IDLE);
        len_d    = h_q;
        unique case (1'b1)
            accept:   len_d = min1(bus.high_cycles);
            high_end: len_d = l_q;
            default:  len_d = h_q;
        endcase
    end

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk    (clk),
        .reset  (reset),
        .load_i (ld_d),
        .len_i  (len_d),
        .dec_i  (dec_d),
        .last_o (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            l_q     <= '0;
            n_q     <= '0;
            pcnt_q  <= '0;
            wave_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        h_q     <= min1(bus.high_cycles);
                        l_q     <= min1(bus.low_cycles);
                        n_q     <= bus.num_pulses;
                        pcnt_q  <= '0;
                        state_q <= HIGH;
                        wave_q  <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        wave_q  <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (last) begin
                        state_q <= LOW;
                        wave_q  <= 1'b0;
                        fall_q  <= 1'b1;
                    end
                end
                LOW: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        wave_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (last) begin
                        if (more) begin
                            state_q <= HIGH;
                            wave_q  <= 1'b1;
                            rise_q  <= 1'b1;
                            if (n_q != '0)
                                pcnt_q <= pcnt_q + CNT_W'(1);
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wave_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wave_out    = wave_q;
    assign bus.rise_strobe = rise_q;
    assign bus.fall_strobe = fall_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_edge_pattern_gen.sv
// Directed bench for edge_pattern_gen.
// Observed vector is {wave_out, rise_strobe, fall_strobe, busy, done}.
module tb_edge_pattern_gen;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    edge_pattern_gen_if #(.CNT_W(16)) bus ();

    edge_pattern_gen #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bus.wave_out, bus.rise_strobe, bus.fall_strobe,
               bus.busy, bus.done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int h, input int l, input int n);
        bus.high_cycles = 16'(h);
        bus.low_cycles  = 16'(l);
        bus.num_pulses  = 16'(n);
    endtask

    logic [4:0] exp2 [12];
    logic [4:0] exp3 [8];

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        cfg(3, 2, 2);

        // 1: reset held with start high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset c%0d", i), 5'b00000);
        end
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("post_reset", 5'b00000);

        // 2: H=3 L=2 N=2, config changed mid-train must be ignored
        exp2 = '{5'b11010, 5'b10010, 5'b10010, 5'b00110, 5'b00010,
                 5'b11010, 5'b10010, 5'b10010, 5'b00110, 5'b00010,
                 5'b00001, 5'b00000};
        cfg(3, 2, 2);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cfg(7, 7, 0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("basic k+%0d", i + 1), exp2[i]);
            @(negedge clk);
        end

        // 3: zero lengths act as one cycle
        exp3 = '{5'b11010, 5'b00110, 5'b11010, 5'b00110,
                 5'b11010, 5'b00110, 5'b00001, 5'b00000};
        cfg(0, 0, 3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("zero k+%0d", i + 1), exp3[i]);
            @(negedge clk);
        end

        // 4: continuous mode aborted in second HIGH cycle
        cfg(4, 4, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort k+1", 5'b11010);
        @(negedge clk);
        chk("abort k+2", 5'b10010);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("abort k+3", 5'b00100);
        @(negedge clk);
        chk("abort k+4", 5'b00000);

        // continuous H=1 L=1 runs past many pulses, then stop from LOW
        cfg(1, 1, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("cont k+%0d", i + 1),
                (i % 2 == 0) ? 5'b11010 : 5'b00110);
            if (i < 9) @(negedge clk);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_low", 5'b00000);
        @(negedge clk);

        // 5: start while busy ignored, start in done cycle accepted
        cfg(2, 1, 1);
        bus.start = 1'b1;
        @(negedge clk);
        chk("coll k+1", 5'b11010);
        @(negedge clk);
        chk("coll k+2", 5'b10010);
        @(negedge clk);
        chk("coll k+3", 5'b00110);
        @(negedge clk);
        chk("coll done", 5'b00001);
        @(negedge clk);
        bus.start = 1'b0;
        chk("coll restart", 5'b11010);
        @(negedge clk);
        chk("coll r+2", 5'b10010);
        @(negedge clk);
        chk("coll r+3", 5'b00110);
        @(negedge clk);
        chk("coll r done", 5'b00001);
        @(negedge clk);
        chk("coll idle", 5'b00000);

        // start together with stop in IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        chk("ss c1", 5'b00000);
        @(negedge clk);
        chk("ss c2", 5'b00000);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(negedge clk);

        // 6: reset in cycle k+3 of a H=5 train, then restart
        cfg(5, 1, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mrst k+1", 5'b11010);
        @(negedge clk);
        chk("mrst k+2", 5'b10010);
        @(negedge clk);
        chk("mrst k+3", 5'b10010);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst k+4", 5'b00000);
        @(negedge clk);
        chk("mrst idle", 5'b00000);
        cfg(2, 1, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rs k+1", 5'b11010);
        @(negedge clk);
        chk("rs k+2", 5'b10010);
        @(negedge clk);
        chk("rs k+3", 5'b00110);
        @(negedge clk);
        chk("rs done", 5'b00001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
